// File: rtl/scanline_vphase_gen_if.sv
// Strobe, configuration and result bundle for the per-line vertical phase
// generator. The master side drives the frame/line strobes and the
// configuration; the slave side is the generator itself.
interface scanline_vphase_gen_if #(
  parameter int LINE_W = 10,
  parameter int INC_W  = 12
);
  logic              frame_start_i;
  logic              line_start_i;
  logic [1:0]        cfg_interpolation_mode;
  logic [INC_W-1:0]  cfg_vscale_inc;
  logic [7:0]        cfg_vphase_init;
  logic [LINE_W-1:0] cfg_vlines_in;
  logic [LINE_W-1:0] src_line_o;
  logic [7:0]        vpos_rel_o;
  logic [7:0]        sl_vpos_rel_o;
  logic              line_valid_o;
  logic              active_o;
  logic              frame_done_o;

  modport master (
    output frame_start_i, line_start_i, cfg_interpolation_mode,
           cfg_vscale_inc, cfg_vphase_init, cfg_vlines_in,
    input  src_line_o, vpos_rel_o, sl_vpos_rel_o, line_valid_o,
           active_o, frame_done_o
  );

  modport slave (
    input  frame_start_i, line_start_i, cfg_interpolation_mode,
           cfg_vscale_inc, cfg_vphase_init, cfg_vlines_in,
    output src_line_o, vpos_rel_o, sl_vpos_rel_o, line_valid_o,
           active_o, frame_done_o
  );
endinterface

// File: rtl/scanline_vphase_gen.sv
// Per-output-line vertical phase generator. A DDA accumulator
// {overflow, line, frac} advances by the scale increment on every line
// strobe; the registered outputs report the source line and the 1/256
// sub-line position. In integer mode the scanline position is shifted by
// half a source line so scanlines sit on source-line transitions.
module scanline_vphase_gen #(
  parameter int LINE_W = 10,
  parameter int INC_W  = 12
) (
  input logic                  mclk,
  input logic                  nrst,
  scanline_vphase_gen_if.slave vif
);

  localparam int ACC_W = LINE_W + 1 + 8;
  localparam logic [INC_W-1:0] INC_ONE = INC_W'(9'h100);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_r, state_next_s;
  logic [ACC_W-1:0]  acc_r, acc_next_s, acc_sum_s;
  logic [INC_W-1:0]  inc_r, inc_next_s;
  logic [LINE_W-1:0] lines_r, lines_next_s;
  logic              mode_int_r, mode_int_next_s;
  logic [LINE_W-1:0] src_line_r, src_line_next_s;
  logic [7:0]        vpos_r, vpos_next_s;
  logic [7:0]        sl_vpos_r, sl_vpos_next_s;
  logic              valid_r, valid_next_s;
  logic              done_r, done_next_s;
  logic              sum_done_s;

  // Next accumulator value and whether it ends the frame: overflow bit set
  // or the line field has reached the latched source line count.
  always_comb begin
    acc_sum_s  = acc_r + {{(ACC_W-INC_W){1'b0}}, inc_r};
    sum_done_s = acc_sum_s[ACC_W-1] || (acc_sum_s[ACC_W-2:8] >= lines_r);
  end

  // Frame state machine and output/accumulator next values; a frame strobe
  // always wins over a coincident line strobe.
  always_comb begin
    state_next_s    = state_r;
    acc_next_s      = acc_r;
    inc_next_s      = inc_r;
    lines_next_s    = lines_r;
    mode_int_next_s = mode_int_r;
    src_line_next_s = src_line_r;
    vpos_next_s     = vpos_r;
    sl_vpos_next_s  = sl_vpos_r;
    valid_next_s    = 1'b0;
    done_next_s     = 1'b0;
    if (vif.frame_start_i) begin
      inc_next_s      = (vif.cfg_vscale_inc == {INC_W{1'b0}}) ? INC_ONE : vif.cfg_vscale_inc;
      lines_next_s    = vif.cfg_vlines_in;
      mode_int_next_s = (vif.cfg_interpolation_mode == 2'b00);
      acc_next_s      = {1'b0, {LINE_W{1'b0}}, vif.cfg_vphase_init};
      if (vif.cfg_vlines_in == {LINE_W{1'b0}}) begin
        state_next_s = ST_DONE;
        done_next_s  = 1'b1;
      end else begin
        state_next_s = ST_ACTIVE;
      end
    end else begin
      case (state_r)
        ST_ACTIVE: begin
          if (vif.line_start_i) begin
            src_line_next_s = acc_r[ACC_W-2:8];
            vpos_next_s     = acc_r[7:0];
            sl_vpos_next_s  = mode_int_r ? (acc_r[7:0] + 8'h80) : acc_r[7:0];
            valid_next_s    = 1'b1;
            acc_next_s      = acc_sum_s;
            if (sum_done_s) begin
              state_next_s = ST_DONE;
              done_next_s  = 1'b1;
            end else begin
              state_next_s = ST_ACTIVE;
            end
          end else begin
            state_next_s = ST_ACTIVE;
          end
        end
        ST_IDLE: state_next_s = ST_IDLE;
        ST_DONE: state_next_s = ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State, accumulator, latched configuration and registered outputs.
  always_ff @(posedge mclk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= ST_IDLE;
      acc_r      <= {ACC_W{1'b0}};
      inc_r      <= INC_ONE;
      lines_r    <= {LINE_W{1'b0}};
      mode_int_r <= 1'b0;
      src_line_r <= {LINE_W{1'b0}};
      vpos_r     <= 8'h00;
      sl_vpos_r  <= 8'h00;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      acc_r      <= acc_next_s;
      inc_r      <= inc_next_s;
      lines_r    <= lines_next_s;
      mode_int_r <= mode_int_next_s;
      src_line_r <= src_line_next_s;
      vpos_r     <= vpos_next_s;
      sl_vpos_r  <= sl_vpos_next_s;
      valid_r    <= valid_next_s;
      done_r     <= done_next_s;
    end
  end

  assign vif.src_line_o    = src_line_r;
  assign vif.vpos_rel_o    = vpos_r;
  assign vif.sl_vpos_rel_o = sl_vpos_r;
  assign vif.line_valid_o  = valid_r;
  assign vif.frame_done_o  = done_r;
  assign vif.active_o      = (state_r == ST_ACTIVE);

endmodule

// File: tb/tb_scanline_vphase_gen.sv
// Self-checking bench for scanline_vphase_gen: directed frames from the
// test plan plus randomized strobes/configuration, checked every cycle
// against an arithmetic model (position of line k = phase + k * increment).
module tb_scanline_vphase_gen;
  localparam int LINE_W = 10;
  localparam int INC_W  = 12;

  logic mclk;
  logic nrst;
  int   n_checks = 0;
  int   n_errors = 0;

  scanline_vphase_gen_if #(.LINE_W(LINE_W), .INC_W(INC_W)) vif ();

  scanline_vphase_gen #(.LINE_W(LINE_W), .INC_W(INC_W)) dut (
    .mclk (mclk),
    .nrst (nrst),
    .vif  (vif)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Reference model state
  int m_active, m_inc, m_lines, m_int, m_phase, m_k;
  int e_src, e_vpos, e_sl, e_valid, e_done;
  int cnt_valid, cnt_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_k = 0;
    e_src = 0; e_vpos = 0; e_sl = 0; e_valid = 0; e_done = 0;
  endtask

  task automatic model_step(input logic fs, input logic ls);
    int pos, npos;
    e_valid = 0;
    e_done  = 0;
    if (fs) begin
      m_inc   = (vif.cfg_vscale_inc == 0) ? 256 : int'(vif.cfg_vscale_inc);
      m_lines = int'(vif.cfg_vlines_in);
      m_int   = (vif.cfg_interpolation_mode == 2'b00) ? 1 : 0;
      m_phase = int'(vif.cfg_vphase_init);
      m_k     = 0;
      if (m_lines == 0) begin
        m_active = 0;
        e_done   = 1;
      end else begin
        m_active = 1;
      end
    end else if (ls && m_active != 0) begin
      pos     = m_phase + m_k * m_inc;
      e_src   = pos / 256;
      e_vpos  = pos % 256;
      e_sl    = (m_int != 0) ? ((e_vpos + 128) % 256) : e_vpos;
      e_valid = 1;
      m_k++;
      npos = m_phase + m_k * m_inc;
      if ((npos / 256) >= m_lines || npos >= (1 << (LINE_W + 8))) begin
        m_active = 0;
        e_done   = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("line_valid", 32'(vif.line_valid_o), 32'(e_valid));
    check_val("frame_done", 32'(vif.frame_done_o), 32'(e_done));
    check_val("active", 32'(vif.active_o), 32'(m_active));
    check_val("src_line", 32'(vif.src_line_o), 32'(e_src));
    check_val("vpos_rel", 32'(vif.vpos_rel_o), 32'(e_vpos));
    check_val("sl_vpos_rel", 32'(vif.sl_vpos_rel_o), 32'(e_sl));
  endtask

  task automatic step(input logic fs, input logic ls);
    vif.frame_start_i = fs;
    vif.line_start_i  = ls;
    model_step(fs, ls);
    @(posedge mclk);
    #1;
    if (vif.line_valid_o) cnt_valid++;
    if (vif.frame_done_o) cnt_done++;
    compare_all();
    vif.frame_start_i = 1'b0;
    vif.line_start_i  = 1'b0;
  endtask

  task automatic set_cfg(input int inc, input int phase, input int lines, input int mode);
    vif.cfg_vscale_inc         = INC_W'(inc);
    vif.cfg_vphase_init        = 8'(phase);
    vif.cfg_vlines_in          = LINE_W'(lines);
    vif.cfg_interpolation_mode = 2'(mode);
  endtask

  task automatic run_frame(input string tag, input int inc, input int phase, input int lines,
                           input int mode, input int n_strobes, input int gap,
                           input int exp_valids, input int exp_dones);
    cnt_valid = 0;
    cnt_done  = 0;
    set_cfg(inc, phase, lines, mode);
    step(1'b1, 1'b0);
    // scramble configuration after the frame strobe; it must have no effect
    set_cfg(int'($urandom), int'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
    for (int i = 0; i < n_strobes; i++) begin
      step(1'b0, 1'b1);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check_val({tag, "_valids"}, 32'(cnt_valid), 32'(exp_valids));
    check_val({tag, "_dones"}, 32'(cnt_done), 32'(exp_dones));
  endtask

  initial begin
    vif.frame_start_i = 1'b0;
    vif.line_start_i  = 1'b0;
    set_cfg(0, 0, 0, 0);
    model_reset();
    nrst = 1'b0;
    #12;
    check_val("reset_src", 32'(vif.src_line_o), 32'd0);
    check_val("reset_active", 32'(vif.active_o), 32'd0);
    check_val("reset_done", 32'(vif.frame_done_o), 32'd0);
    @(negedge mclk);
    nrst = 1'b1;
    step(1'b0, 1'b1);

    // unit scale, non-integer mode: lines 0..3, 5th strobe ignored
    run_frame("unit", 32'h100, 0, 4, 1, 5, 0, 4, 1);
    check_val("unit_last_src", 32'(vif.src_line_o), 32'd3);
    check_val("unit_last_vpos", 32'(vif.vpos_rel_o), 32'h00);

    // half scale, integer mode with half-line scanline shift
    run_frame("half", 32'h080, 0, 2, 0, 5, 1, 4, 1);
    check_val("half_last_src", 32'(vif.src_line_o), 32'd1);
    check_val("half_last_vpos", 32'(vif.vpos_rel_o), 32'h80);
    check_val("half_last_sl", 32'(vif.sl_vpos_rel_o), 32'h00);

    // fractional step with initial phase
    run_frame("frac", 32'h0D5, 32'h40, 3, 1, 5, 0, 4, 1);
    check_val("frac_last_src", 32'(vif.src_line_o), 32'd2);
    check_val("frac_last_vpos", 32'(vif.vpos_rel_o), 32'hBF);

    // zero source lines: done pulse only
    run_frame("zero_lines", 32'h100, 0, 0, 1, 3, 0, 0, 1);

    // zero increment behaves as 1.0
    run_frame("zero_inc", 0, 32'h10, 3, 1, 4, 0, 3, 1);
    check_val("zero_inc_last_src", 32'(vif.src_line_o), 32'd2);
    check_val("zero_inc_last_vpos", 32'(vif.vpos_rel_o), 32'h10);

    // max increment, max lines: frame ends through the overflow bit
    run_frame("max", 32'hFFF, 32'hFF, 1023, 1, 70, 0, 64, 1);
    check_val("max_last_src", 32'(vif.src_line_o), 32'd1008);
    check_val("max_last_vpos", 32'(vif.vpos_rel_o), 32'hC0);

    // frame strobe coincident with line strobe
    set_cfg(32'h100, 32'h20, 5, 1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    set_cfg(32'h100, 32'h33, 5, 1);
    step(1'b1, 1'b1);
    check_val("coinc_no_valid", 32'(vif.line_valid_o), 32'd0);
    step(1'b0, 1'b1);
    check_val("coinc_src", 32'(vif.src_line_o), 32'd0);
    check_val("coinc_vpos", 32'(vif.vpos_rel_o), 32'h33);

    // asynchronous reset mid-frame
    set_cfg(32'h100, 32'h44, 8, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check_val("arst_src", 32'(vif.src_line_o), 32'd0);
    check_val("arst_vpos", 32'(vif.vpos_rel_o), 32'd0);
    check_val("arst_sl", 32'(vif.sl_vpos_rel_o), 32'd0);
    check_val("arst_active", 32'(vif.active_o), 32'd0);
    check_val("arst_valid", 32'(vif.line_valid_o), 32'd0);
    check_val("arst_done", 32'(vif.frame_done_o), 32'd0);
    @(negedge mclk);
    nrst = 1'b1;
    cnt_done = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_val("arst_no_done", 32'(cnt_done), 32'd0);
    run_frame("after_rst", 32'h100, 32'h44, 2, 0, 3, 0, 2, 1);

    // randomized strobes and configuration
    for (int c = 0; c < 4000; c++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        set_cfg(32'hFFF, int'($urandom_range(0, 255)), 1023, int'($urandom_range(0, 3)));
      end else begin
        set_cfg((sel < 3) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 3)));
      end
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
